// File: rtl/i2c_reg_access_arbiter_if.sv
// Register-access arbiter <-> i2c_master connection.
// The "master" modport is the arbiter side, which drives the master's start/config inputs.
// The "slave" modport is the i2c_master side.
interface i2c_reg_access_arbiter_if;
    logic       m_start;
    logic [7:0] m_nbytes;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_write_data;
    logic       m_tx_data_req;
    logic [7:0] m_read_data;
    logic       m_rx_data_ready;
    logic       m_idle;
    logic       m_failed;
    logic       m_timeout;

    modport master (
        output m_start, m_nbytes, m_addr, m_rw, m_write_data,
        input  m_tx_data_req, m_read_data, m_rx_data_ready, m_idle, m_failed, m_timeout
    );

    modport slave (
        input  m_start, m_nbytes, m_addr, m_rw, m_write_data,
        output m_tx_data_req, m_read_data, m_rx_data_ready, m_idle, m_failed, m_timeout
    );
endinterface

// File: rtl/i2c_reg_access_arbiter.sv
// Shares one i2c_master between two requesters (round-robin) and sequences
// register writes (addr, pointer, data) and register reads (pointer write,
// STOP, bus-free gap, then a 1-4 byte read).
module i2c_reg_access_arbiter #(
    parameter int unsigned GAP_CYCLES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_rw,
    input  logic [6:0]  req0_dev,
    input  logic [7:0]  req0_reg,
    input  logic [1:0]  req0_len,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_rw,
    input  logic [6:0]  req1_dev,
    input  logic [7:0]  req1_reg,
    input  logic [1:0]  req1_len,
    input  logic [31:0] req1_wdata,
    output logic        done0,
    output logic        done1,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic [31:0] resp_rdata,
    i2c_reg_access_arbiter_if.master bus
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StGrant, StStartWr, StXferWr, StGap, StStartRd, StXferRd, StDone
    } state_e;

    state_e state_q, state_d;

    logic            last_grant_q;
    logic            grant_q;
    logic            rw_q;
    logic [1:0]      len_q;
    logic [7:0]      tx_buf_q [5];
    logic [2:0]      idx_q;
    logic [2:0]      rcount_q, rcount_d;
    logic [31:0]     acc_q, acc_d;
    logic            err_q, err_d;
    logic            tmo_q, tmo_d;
    logic [GapW-1:0] gap_q;
    logic            xfer_seen_q;
    logic [6:0]      m_addr_q;
    logic [7:0]      m_nbytes_q;
    logic            m_rw_q;
    logic            resp_err_q;
    logic            resp_tmo_q;
    logic [31:0]     resp_rdata_q;

    logic            grant_sel;
    logic            sel_valid;
    logic            sel_rw;
    logic [6:0]      sel_dev;
    logic [7:0]      sel_reg;
    logic [1:0]      sel_len;
    logic [31:0]     sel_wdata;
    logic            err_state;
    logic            idle_ok;

    // Arbitration choice in IDLE and the field mux for the requester being granted
    always_comb begin
        grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        sel_valid = grant_q ? req1_valid : req0_valid;
        sel_rw    = grant_q ? req1_rw    : req0_rw;
        sel_dev   = grant_q ? req1_dev   : req0_dev;
        sel_reg   = grant_q ? req1_reg   : req0_reg;
        sel_len   = grant_q ? req1_len   : req0_len;
        sel_wdata = grant_q ? req1_wdata : req0_wdata;
        err_state = (state_q == StXferWr) || (state_q == StGap) || (state_q == StXferRd);
        // The master may lag a cycle in dropping idle after a start, so ignore it until then
        idle_ok   = xfer_seen_q && bus.m_idle;
    end

    // Error latches and read-byte accumulator next state
    always_comb begin
        err_d    = err_q;
        tmo_d    = tmo_q;
        acc_d    = acc_q;
        rcount_d = rcount_q;
        if (state_q == StGrant) begin
            err_d    = 1'b0;
            tmo_d    = 1'b0;
            acc_d    = '0;
            rcount_d = '0;
        end
        if (err_state) begin
            if (bus.m_failed) begin
                err_d = 1'b1;
            end
            if (bus.m_timeout) begin
                err_d = 1'b1;
                tmo_d = 1'b1;
            end
        end
        if (state_q == StXferRd && bus.m_rx_data_ready) begin
            // Bytes beyond the requested length are dropped
            if (rcount_q <= {1'b0, len_q}) begin
                acc_d[{rcount_q[1:0], 3'b000} +: 8] = bus.m_read_data;
            end
            if (rcount_q != 3'd4) begin
                rcount_d = rcount_q + 3'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if ((req0_valid || req1_valid) && bus.m_idle) begin
                    state_d = StGrant;
                end
            end
            // A requester that withdrew before ready is simply not served
            StGrant:   state_d = sel_valid ? StStartWr : StIdle;
            StStartWr: state_d = StXferWr;
            StXferWr: begin
                if (idle_ok) begin
                    state_d = (err_d || !rw_q) ? StDone : StGap;
                end
            end
            StGap: begin
                if (gap_q == '0 && bus.m_idle) begin
                    state_d = StStartRd;
                end
            end
            StStartRd: state_d = StXferRd;
            StXferRd: begin
                if (idle_ok) begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake pulses, master start and write-data feed
    always_comb begin
        req0_ready        = (state_q == StGrant) && !grant_q && req0_valid;
        req1_ready        = (state_q == StGrant) && grant_q && req1_valid;
        done0             = (state_q == StDone) && !grant_q;
        done1             = (state_q == StDone) && grant_q;
        bus.m_start       = (state_q == StStartWr) || (state_q == StStartRd);
        bus.m_write_data  = 8'h00;
        if (state_q == StStartWr || state_q == StXferWr) begin
            bus.m_write_data = tx_buf_q[idx_q];
        end
        bus.m_addr        = m_addr_q;
        bus.m_nbytes      = m_nbytes_q;
        bus.m_rw          = m_rw_q;
        resp_err          = resp_err_q;
        resp_timeout      = resp_tmo_q;
        resp_rdata        = resp_rdata_q;
    end

    // Datapath: request capture, byte index, gap timer, master config and response hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            rw_q         <= 1'b0;
            len_q        <= '0;
            for (int i = 0; i < 5; i++) begin
                tx_buf_q[i] <= '0;
            end
            idx_q        <= '0;
            rcount_q     <= '0;
            acc_q        <= '0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            gap_q        <= '0;
            xfer_seen_q  <= 1'b0;
            m_addr_q     <= '0;
            m_nbytes_q   <= '0;
            m_rw_q       <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_tmo_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            acc_q       <= acc_d;
            rcount_q    <= rcount_d;
            xfer_seen_q <= (state_q == StXferWr) || (state_q == StXferRd);

            if (state_q == StIdle && state_d == StGrant) begin
                grant_q <= grant_sel;
            end

            if (state_q == StGrant && sel_valid) begin
                last_grant_q <= grant_q;
                rw_q         <= sel_rw;
                len_q        <= sel_len;
                tx_buf_q[0]  <= sel_reg;
                tx_buf_q[1]  <= sel_wdata[7:0];
                tx_buf_q[2]  <= sel_wdata[15:8];
                tx_buf_q[3]  <= sel_wdata[23:16];
                tx_buf_q[4]  <= sel_wdata[31:24];
                idx_q        <= '0;
                // Config for the pointer-write phase; a read only sends the pointer here
                m_addr_q     <= sel_dev;
                m_rw_q       <= 1'b0;
                m_nbytes_q   <= sel_rw ? 8'd1 : ({6'd0, sel_len} + 8'd2);
            end

            if (state_q == StXferWr && bus.m_tx_data_req && idx_q != 3'd4) begin
                idx_q <= idx_q + 3'd1;
            end

            if (state_q == StXferWr && state_d == StGap) begin
                gap_q <= GapW'(GAP_CYCLES);
            end else if (state_q == StGap && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end

            if (state_q == StGap && state_d == StStartRd) begin
                m_rw_q     <= 1'b1;
                m_nbytes_q <= {6'd0, len_q} + 8'd1;
            end

            // Response fields change only when a transaction completes
            if (state_d == StDone && state_q != StDone) begin
                resp_err_q   <= err_d;
                resp_tmo_q   <= tmo_d;
                resp_rdata_q <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_access_arbiter.sv
// Bench for i2c_reg_access_arbiter: directed vector table plus hand-written
// arbitration and mid-read reset sequences, with a simple i2c_master model.
module tb_i2c_reg_access_arbiter;

    localparam int unsigned Gap = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_rw;
    logic [6:0]  req0_dev;
    logic [7:0]  req0_reg;
    logic [1:0]  req0_len;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_rw;
    logic [6:0]  req1_dev;
    logic [7:0]  req1_reg;
    logic [1:0]  req1_len;
    logic [31:0] req1_wdata;
    logic        done0, done1, resp_err, resp_timeout;
    logic [31:0] resp_rdata;

    i2c_reg_access_arbiter_if bus ();

    i2c_reg_access_arbiter #(.GAP_CYCLES(Gap)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rw      (req0_rw),
        .req0_dev     (req0_dev),
        .req0_reg     (req0_reg),
        .req0_len     (req0_len),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rw      (req1_rw),
        .req1_dev     (req1_dev),
        .req1_reg     (req1_reg),
        .req1_len     (req1_len),
        .req1_wdata   (req1_wdata),
        .done0        (done0),
        .done1        (done1),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .resp_rdata   (resp_rdata),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int d_cnt    = 0;
    int r_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0 || done1) d_cnt <= d_cnt + 1;
        if (req0_ready || req1_ready) r_cnt <= r_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- i2c_master model ----------------
    // mode 0 = ACK all, 1 = address NACK, 2 = SCL held low (timeout), 3 = one extra read byte
    int          slave_mode = 0;
    logic [31:0] slave_data = '0;
    logic [7:0]  bus_q [$];
    logic [7:0]  exp_q [$];
    int          st_nb [$];
    logic        st_rw [$];
    int          st_cyc [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve();
        int   nb;
        int   n;
        logic rw;
        nb = int'(bus.m_nbytes);
        rw = bus.m_rw;
        st_nb.push_back(nb);
        st_rw.push_back(rw);
        st_cyc.push_back(cyc);
        bus_q.push_back({bus.m_addr, rw});
        bus.m_idle = 1'b0;
        if (slave_mode == 1) begin
            repeat (3) tick();
            bus.m_failed = 1'b1;
            tick();
            bus.m_failed = 1'b0;
        end else if (slave_mode == 2) begin
            repeat (5) tick();
            bus.m_timeout = 1'b1;
            tick();
            bus.m_timeout = 1'b0;
        end else if (!rw) begin
            for (int i = 0; i < nb; i++) begin
                repeat (3) tick();
                bus_q.push_back(bus.m_write_data);
                bus.m_tx_data_req = 1'b1;
                tick();
                bus.m_tx_data_req = 1'b0;
            end
            repeat (2) tick();
        end else begin
            n = (slave_mode == 3) ? nb + 1 : nb;
            for (int i = 0; i < n; i++) begin
                repeat (3) tick();
                bus.m_read_data = slave_data[8 * (i % 4) +: 8];
                bus.m_rx_data_ready = 1'b1;
                tick();
                bus.m_rx_data_ready = 1'b0;
            end
            repeat (2) tick();
        end
        bus.m_idle = 1'b1;
    endtask

    initial begin
        bus.m_idle          = 1'b1;
        bus.m_tx_data_req   = 1'b0;
        bus.m_read_data     = 8'h00;
        bus.m_rx_data_ready = 1'b0;
        bus.m_failed        = 1'b0;
        bus.m_timeout       = 1'b0;
        forever begin
            tick();
            if (bus.m_start === 1'b1) serve();
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit        who;
        bit        rw;
        bit [6:0]  dev;
        bit [7:0]  rg;
        bit [1:0]  len;
        bit [31:0] wdata;
        int        mode;
        bit [31:0] sdata;
        bit        exp_err;
        bit        exp_tmo;
        bit [31:0] exp_rdata;
        int        exp_starts;
        int        exp_nb0;
        int        exp_nb1;
    } vec_t;

    vec_t vecs [8];

    task automatic drive_req(input bit who, input bit valid, input vec_t v);
        if (!who) begin
            req0_valid = valid; req0_rw = v.rw; req0_dev = v.dev;
            req0_reg = v.rg; req0_len = v.len; req0_wdata = v.wdata;
        end else begin
            req1_valid = valid; req1_rw = v.rw; req1_dev = v.dev;
            req1_reg = v.rg; req1_len = v.len; req1_wdata = v.wdata;
        end
    endtask

    task automatic issue(input vec_t v, input string tag);
        bit ok;
        slave_mode = v.mode;
        slave_data = v.sdata;
        bus_q.delete();
        st_nb.delete();
        st_rw.delete();
        st_cyc.delete();
        drive_req(v.who, 1'b1, v);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((v.who ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " ready"}, ok, 1);
        @(posedge clk);
        #1;
        drive_req(v.who, 1'b0, v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit          ok;
        bit          line;
        bit          e;
        bit          t;
        logic [31:0] rd;
        logic [31:0] w;
        issue(v, tag);
        ok = 1'b0;
        line = 1'b0; e = 1'b0; t = 1'b0; rd = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                ok = 1'b1; line = done1; e = resp_err; t = resp_timeout; rd = resp_rdata;
                break;
            end
        end
        check({tag, " done seen"}, ok, 1);
        check({tag, " done line"}, line, v.who);
        check({tag, " resp_err"}, e, v.exp_err);
        check({tag, " resp_timeout"}, t, v.exp_tmo);
        check({tag, " resp_rdata"}, rd, v.exp_rdata);
        check({tag, " start count"}, st_nb.size(), v.exp_starts);
        if (st_nb.size() >= 1) begin
            check({tag, " nbytes phase1"}, st_nb[0], v.exp_nb0);
            check({tag, " rw phase1"}, st_rw[0], 0);
        end
        if (v.exp_starts == 2 && st_nb.size() >= 2) begin
            check({tag, " nbytes phase2"}, st_nb[1], v.exp_nb1);
            check({tag, " rw phase2"}, st_rw[1], 1);
            check({tag, " gap >= GAP_CYCLES"}, (st_cyc[1] - st_cyc[0]) >= Gap, 1);
        end
        exp_q.delete();
        exp_q.push_back({v.dev, 1'b0});
        if (v.mode == 0 || v.mode == 3) begin
            exp_q.push_back(v.rg);
            w = v.wdata;
            if (!v.rw) begin
                for (int i = 0; i <= int'(v.len); i++) exp_q.push_back(w[8 * i +: 8]);
            end else begin
                exp_q.push_back({v.dev, 1'b1});
            end
        end
        check({tag, " bus byte count"}, bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) begin
            check($sformatf("%s bus byte %0d", tag, i), bus_q[i], exp_q[i]);
        end
        for (int i = 0; i < 500 && bus.m_idle !== 1'b1; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_model_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.m_idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("model returns idle", ok, 1);
    endtask

    function automatic logic [63:0] all_outputs();
        return {1'b0, req0_ready, req1_ready, done0, done1, resp_err, resp_timeout, resp_rdata,
                bus.m_start, bus.m_nbytes, bus.m_addr, bus.m_rw, bus.m_write_data};
    endfunction

    initial begin
        vec_t vr;
        vec_t va0;
        vec_t va1;
        int   acc_n;
        int   dn_n;
        int   dcnt0;
        bit   exp_g;
        bit   last_acc;

        //          who rw dev    reg    len  wdata         mode sdata        err tmo rdata        st nb0 nb1
        vecs[0] = '{0, 0, 7'h44, 8'h30, 2'd1, 32'h0000BEEF, 0, 32'h0,        0, 0, 32'h0,        1, 3, 0};
        vecs[1] = '{1, 1, 7'h50, 8'h10, 2'd3, 32'h0,        0, 32'h44332211, 0, 0, 32'h44332211, 2, 1, 4};
        vecs[2] = '{0, 1, 7'h2A, 8'h05, 2'd0, 32'h0,        0, 32'hA5A5A55A, 0, 0, 32'h0000005A, 2, 1, 1};
        vecs[3] = '{1, 1, 7'h50, 8'h10, 2'd2, 32'h0,        1, 32'hFFFFFFFF, 1, 0, 32'h0,        1, 1, 0};
        vecs[4] = '{0, 0, 7'h10, 8'h01, 2'd3, 32'h12345678, 2, 32'h0,        1, 1, 32'h0,        1, 5, 0};
        vecs[5] = '{1, 0, 7'h7F, 8'hFF, 2'd3, 32'hCAFEF00D, 0, 32'h0,        0, 0, 32'h0,        1, 5, 0};
        vecs[6] = '{0, 1, 7'h33, 8'h44, 2'd1, 32'h0,        3, 32'hDDCCBBAA, 0, 0, 32'h0000BBAA, 2, 1, 2};
        vecs[7] = '{1, 0, 7'h01, 8'h80, 2'd0, 32'h000000AB, 0, 32'h0,        0, 0, 32'h0,        1, 2, 0};

        drive_req(1'b0, 1'b0, vecs[0]);
        drive_req(1'b1, 1'b0, vecs[1]);
        #1;
        check("reset outputs", all_outputs(), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post-reset outputs", all_outputs(), 64'h0);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Both requesters continuously valid: grants must alternate starting with req0
        va0 = '{0, 0, 7'h21, 8'h01, 2'd0, 32'h11, 0, 32'h0, 0, 0, 32'h0, 1, 2, 0};
        va1 = '{1, 0, 7'h22, 8'h02, 2'd0, 32'h22, 0, 32'h0, 0, 0, 32'h0, 1, 2, 0};
        slave_mode = 0;
        drive_req(1'b0, 1'b1, va0);
        drive_req(1'b1, 1'b1, va1);
        acc_n = 0; dn_n = 0; exp_g = 1'b0; last_acc = 1'b0;
        for (int i = 0; i < 20000 && dn_n < 8; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                check($sformatf("arb done %0d line", dn_n), done1, last_acc);
                dn_n++;
            end
            if (req0_ready || req1_ready) begin
                check($sformatf("arb grant %0d", acc_n), {req1_ready, req0_ready},
                      exp_g ? 2'b10 : 2'b01);
                last_acc = req1_ready;
                exp_g = ~exp_g;
                acc_n++;
                if (acc_n == 8) begin
                    @(posedge clk);
                    #1;
                    drive_req(1'b0, 1'b0, va0);
                    drive_req(1'b1, 1'b0, va1);
                end
            end
        end
        check("arb accepts", acc_n, 8);
        check("arb dones", dn_n, 8);
        wait_model_idle();
        repeat (40) @(posedge clk);
        check("no stray accept/done", d_cnt, r_cnt);

        // Reset asserted in the middle of the read phase
        vr = '{0, 1, 7'h3C, 8'h22, 2'd2, 32'h0, 0, 32'h00C0B0A0, 0, 0, 32'h00C0B0A0, 2, 1, 3};
        issue(vr, "rst-read");
        for (int i = 0; i < 500 && st_nb.size() < 2; i++) @(negedge clk);
        check("rst-read reached read phase", st_nb.size(), 2);
        repeat (5) @(posedge clk);
        #2;
        check("rst-read nbytes before reset", bus.m_nbytes, 3);
        dcnt0 = d_cnt;
        rst_n = 1'b0;
        #1;
        check("outputs zero at reset assert", all_outputs(), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_model_idle();
        repeat (10) @(negedge clk);
        check("no done after abort", d_cnt, dcnt0);
        @(posedge clk);
        #1;
        run_vec(vr, "post-reset read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_reg_access_arbiter.md
Name: i2c_reg_access_arbiter

Overview:
Sequences register-level I2C transactions on a single i2c_master instance and shares that master between two requesters using round-robin arbitration. Each request is one register write (pointer plus 1-4 data bytes) or one register read (pointer write, STOP, then a 1-4 byte read). The block feeds bytes to the master on its tx_data_req, collects read bytes, and returns one response per request with error and timeout status. It sits between the I2C master and the system-side device drivers.

Parameters:
GAP_CYCLES, 250, clk cycles of bus-free time between a pointer-write STOP and the following read START (5 us at 50 MHz); minimum 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request pending; fields held stable until matching ready
req0_ready / req1_ready  out  1  one-cycle accept pulse; request fields captured this cycle
reqK_rw  in  1  per requester; 0 = register write, 1 = register read
reqK_dev  in  7  per requester; 7-bit slave address
reqK_reg  in  8  per requester; register pointer byte
reqK_len  in  2  per requester; payload length minus 1 (0 means 1 byte, 3 means 4 bytes)
reqK_wdata  in  32  per requester; write payload, byte 0 = bits [7:0], sent first
done0 / done1  out  1  one-cycle completion pulse to the owning requester
resp_err  out  1  valid with doneK; master reported a failure (NACK or timeout)
resp_timeout  out  1  valid with doneK; master reported a timeout
resp_rdata  out  32  valid with doneK; read bytes, first received in [7:0]; unread bytes are 0
m_start  out  1  to master start_trigger; one-cycle pulse
m_nbytes  out  8  to master nbytes_in
m_addr  out  7  to master addr_in
m_rw  out  1  to master rw_mode
m_write_data  out  8  to master write_data
m_tx_data_req  in  1  from master
m_read_data  in  8  from master
m_rx_data_ready  in  1  from master
m_idle  in  1  from master idle
m_failed  in  1  from master tranfer_failed
m_timeout  in  1  from master tranfer_timeout

Behaviour:
- Reset values: all outputs 0. Internal state: FSM to IDLE, last_grant = 1 (so req0 wins first), byte index 0, error flags clear.
- Reset asserted mid-transaction: the FSM aborts immediately with no done pulse. The master recovers through its own timeout and idle logic.
- FSM states: IDLE, GRANT, START_WR, XFER_WR, GAP, START_RD, XFER_RD, DONE.
- IDLE:
  - If any reqK_valid and m_idle=1, go to GRANT.
  - If both are valid, grant the requester that is not last_grant.
- GRANT (1 cycle):
  - Pulse reqK_ready.
  - Capture rw, dev, reg, len, wdata into a tx buffer: byte0 = reg, bytes 1..4 = wdata LSB first.
  - Update last_grant, clear resp_rdata accumulator, set byte index 0, go to START_WR.
- START_WR:
  - Drive m_addr = dev, m_rw = 0, m_write_data = buf[0].
  - m_nbytes = len+2 for a write; m_nbytes = 1 for a read.
  - Pulse m_start for exactly one cycle, go to XFER_WR.
- XFER_WR:
  - m_write_data = buf[idx]. Each m_tx_data_req increments idx, saturating at 4.
  - Accept m_idle only from the second cycle after m_start.
  - On m_idle=1:
    - If an error was latched, or rw=0, go to DONE.
    - Otherwise load the gap counter with GAP_CYCLES and go to GAP.
- GAP: decrement the counter; at 0 with m_idle=1, go to START_RD.
- START_RD: m_rw = 1, m_nbytes = len+1; pulse m_start; go to XFER_RD.
- XFER_RD:
  - Each m_rx_data_ready writes m_read_data into resp_rdata byte[rcount], then rcount++.
  - Bytes beyond len+1 are ignored.
  - On m_idle=1 (same guard as XFER_WR), go to DONE.
- Error latching (XFER_WR, GAP, XFER_RD): m_failed sets err; m_timeout sets err and tmo. Both stay latched until DONE.
- DONE (1 cycle):
  - Pulse doneK for the granted requester, with resp_err, resp_timeout, resp_rdata valid.
  - Return to IDLE. Response fields hold their values until the next DONE.
- m_addr, m_nbytes and m_rw are held stable from START_WR/START_RD until the next start.
- A requester whose valid drops before ready is simply not served; no partial state is kept.

Test Plan:
- req0 write (dev 0x44, reg 0x30, len 1, wdata 0xBEEF) with a slave model ACKing all bytes → one m_start with m_nbytes=3; bus shows 0x88, 0x30, 0xEF, 0xBE; done0 pulses with resp_err=0.
- req1 read (dev 0x50, reg 0x10, len 3) with the slave returning 11 22 33 44 → two m_start pulses: nbytes 1 with rw 0, then nbytes 4 with rw 1. The starts are separated by at least GAP_CYCLES. done1 pulses with resp_rdata=0x44332211.
- req0 and req1 valid in the same cycle, repeated 4 times → grants alternate 0,1,0,1; exactly one done per accept; no request is starved.
- Slave NACKs the address on a read → m_failed pulses, no read phase starts, done pulses with resp_err=1, resp_timeout=0, resp_rdata=0.
- Slave holds SCL low → m_timeout pulses; done pulses with resp_err=1 and resp_timeout=1; the next request completes normally.
- rst_n asserted during XFER_RD → all outputs are 0 on the same edge and no done pulse occurs; after release, a fresh req0 read completes correctly.
